// File: rtl/approx_mac_acc.sv
// approx_mac_acc: accumulates a fixed-length group of unsigned 8-bit product
// terms (one per input handshake) into an ACC_W-bit sum, then holds the group
// result on an output handshake until it is consumed.
// Optional build macro APPROX_MAC_ACC_SATURATE_EN: when defined, an addition
// that carries out clamps the sum to all-ones; otherwise the sum wraps.
// In both builds the sticky overflow flag records any carry within the group.
// Handshakes: a transfer happens on a cycle where valid && ready; ready and
// valid are decoded from the state register only, so no input reaches an
// output combinationally.
module approx_mac_acc #(
    parameter int ACC_W = 16,
    parameter int LEN   = 8,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_z,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             in_fire;
    logic             out_fire;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] add_res;
    logic [CNT_W-1:0] count_inc;

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_acc   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

    // Zero-extended add of the new term; carry-out drives overflow/clamping.
    always_comb begin
        sum_ext   = {1'b0, acc_q} + (ACC_W + 1)'(in_z);
        carry     = sum_ext[ACC_W];
        count_inc = count_q + CNT_W'(1);
`ifdef APPROX_MAC_ACC_SATURATE_EN
        add_res   = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        add_res   = sum_ext[ACC_W-1:0];
`endif
    end

    // Next-state and datapath update; everything holds unless a transfer fires.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    acc_d   = ACC_W'(in_z);
                    count_d = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = ((LEN == 1) || in_last) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (in_fire) begin
                    acc_d   = add_res;
                    count_d = count_inc;
                    ovf_d   = ovf_q | carry;
                    if ((count_inc == CNT_W'(LEN)) || in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_fire) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial or held group.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_approx_mac_acc.sv
// Bench for approx_mac_acc: three instances (16/4, 16/8, 8/3) share one
// stimulus stream; a per-instance reference keeps the exact group sum and
// term count and derives the wrapped or saturated result from them.
module tb_approx_mac_acc;

`ifdef APPROX_MAC_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic [7:0] in_z      = 8'd0;
    logic       in_last   = 1'b0;
    logic       out_ready = 1'b0;

    logic [2:0]  rdy_w, vld_w, ovf_w;
    logic [15:0] acc_a, acc_b;
    logic [7:0]  acc_c;
    logic [2:0]  cnt_a;
    logic [3:0]  cnt_b;
    logic [1:0]  cnt_c;

    approx_mac_acc #(.ACC_W(16), .LEN(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[0]),
        .in_z(in_z), .in_last(in_last), .out_valid(vld_w[0]),
        .out_ready(out_ready), .out_acc(acc_a), .out_count(cnt_a), .out_ovf(ovf_w[0]));

    approx_mac_acc #(.ACC_W(16), .LEN(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[1]),
        .in_z(in_z), .in_last(in_last), .out_valid(vld_w[1]),
        .out_ready(out_ready), .out_acc(acc_b), .out_count(cnt_b), .out_ovf(ovf_w[1]));

    approx_mac_acc #(.ACC_W(8), .LEN(3)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[2]),
        .in_z(in_z), .in_last(in_last), .out_valid(vld_w[2]),
        .out_ready(out_ready), .out_acc(acc_c), .out_count(cnt_c), .out_ovf(ovf_w[2]));

    // ---------------- reference model ----------------
    int  len_m [3] = '{4, 8, 3};
    int  w_m   [3] = '{16, 16, 8};
    int  sum_m [3];   // exact, unbounded group sum
    int  cnt_m [3];   // terms accepted in current group
    bit  pend_m[3];   // group complete, result waiting for downstream

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_acc(input int i);
        case (i)
            0:       return 32'(acc_a);
            1:       return 32'(acc_b);
            default: return 32'(acc_c);
        endcase
    endfunction

    function automatic logic [31:0] obs_cnt(input int i);
        case (i)
            0:       return 32'(cnt_a);
            1:       return 32'(cnt_b);
            default: return 32'(cnt_c);
        endcase
    endfunction

    function automatic logic [31:0] exp_acc(input int i);
        longint maxv;
        maxv = (longint'(1) << w_m[i]) - 1;
        if (longint'(sum_m[i]) <= maxv) return 32'(sum_m[i]);
        if (SAT) return 32'(maxv);
        return 32'(longint'(sum_m[i]) % (maxv + 1));
    endfunction

    function automatic bit exp_ovf(input int i);
        return longint'(sum_m[i]) > ((longint'(1) << w_m[i]) - 1);
    endfunction

    // ---------------- driver ----------------
    // Compare every instance against the model, advance the model with the
    // inputs currently applied, then move to just after the next rising edge.
    task automatic step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("in_ready[%0d]", i),  32'(rdy_w[i]), 32'(!pend_m[i]));
            chk($sformatf("out_valid[%0d]", i), 32'(vld_w[i]), 32'(pend_m[i]));
            chk($sformatf("out_acc[%0d]", i),   obs_acc(i),    exp_acc(i));
            chk($sformatf("out_count[%0d]", i), obs_cnt(i),    32'(cnt_m[i]));
            chk($sformatf("out_ovf[%0d]", i),   32'(ovf_w[i]), 32'(exp_ovf(i)));
        end
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                sum_m[i] = 0; cnt_m[i] = 0; pend_m[i] = 1'b0;
            end else if (pend_m[i]) begin
                if (out_ready) begin
                    sum_m[i] = 0; cnt_m[i] = 0; pend_m[i] = 1'b0;
                end
            end else if (in_valid) begin
                sum_m[i] += int'(in_z);
                cnt_m[i] += 1;
                if (cnt_m[i] == len_m[i] || in_last) pend_m[i] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic term(input logic [7:0] z, input logic last);
        in_valid = 1'b1;
        in_z     = z;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < 3; i++) begin
            sum_m[i] = 0; cnt_m[i] = 0; pend_m[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_in_ready_a",  32'(rdy_w[0]), 32'd1);
        chk("reset_out_valid_a", 32'(vld_w[0]), 32'd0);
        chk("reset_acc_a",       32'(acc_a),    32'd0);
        chk("reset_count_a",     32'(cnt_a),    32'd0);
        step();

        // Full group on the 16/4 instance.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) term(8'd225, 1'b0);
        chk("full_valid",  32'(vld_w[0]), 32'd1);
        chk("full_ready",  32'(rdy_w[0]), 32'd0);
        chk("full_acc",    32'(acc_a),    32'd900);
        chk("full_count",  32'(cnt_a),    32'd4);
        chk("full_ovf",    32'(ovf_w[0]), 32'd0);
        step();
        chk("full_ready_back", 32'(rdy_w[0]), 32'd1);
        step();

        // Early terminator; a lone in_last without in_valid does nothing.
        do_reset();
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        out_ready = 1'b0;
        term(8'd10, 1'b0);
        term(8'd20, 1'b1);
        chk("early_acc_b",   32'(acc_b),    32'd30);
        chk("early_count_b", 32'(cnt_b),    32'd2);
        chk("early_valid_b", 32'(vld_w[1]), 32'd1);
        step();

        // Wrap / saturate on the 8/3 instance, then backpressure while held.
        do_reset();
        for (int k = 0; k < 3; k++) term(8'd100, 1'b0);
        chk("wrap_acc_c", 32'(acc_c),    SAT ? 32'd255 : 32'd44);
        chk("wrap_ovf_c", 32'(ovf_w[2]), 32'd1);
        for (int k = 0; k < 5; k++) term(8'($urandom_range(0, 255)), 1'b0);
        chk("stall_acc_c",   32'(acc_c),    SAT ? 32'd255 : 32'd44);
        chk("stall_ready_c", 32'(rdy_w[2]), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        term(8'd7, 1'b0);
        term(8'd8, 1'b0);
        term(8'd9, 1'b0);
        chk("post_stall_acc_c", 32'(acc_c), 32'd24);
        out_ready = 1'b1;
        step();
        step();

        // Mid-group reset, then a fresh group of four ones.
        do_reset();
        term(8'd50, 1'b0);
        term(8'd50, 1'b0);
        do_reset();
        chk("midrst_acc_a",   32'(acc_a),    32'd0);
        chk("midrst_count_a", 32'(cnt_a),    32'd0);
        chk("midrst_ready_a", 32'(rdy_w[0]), 32'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) term(8'd1, 1'b0);
        chk("fresh_acc_a",   32'(acc_a), 32'd4);
        chk("fresh_count_a", 32'(cnt_a), 32'd4);
        out_ready = 1'b1;
        step();

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_z      = 8'($urandom_range(0, 255));
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
